// File: rtl/da3_pkg.sv
// Shared types and constants for the PmodDA3 sample feeder.
package da3_pkg;

    localparam int DA3_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } da3_feed_state_t;

endpackage

// File: rtl/da3_sample_feeder_if.sv
// Sample stream in, DAC driver handshake out; master is the feeder side.
interface da3_sample_feeder_if;
    import da3_pkg::*;

    logic [DA3_DATA_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DA3_DATA_W-1:0] dac_data;
    logic                  dac_start;
    logic                  dac_done;

    modport master (
        input  s_data, s_valid, dac_done,
        output s_ready, dac_data, dac_start
    );

    modport slave (
        output s_data, s_valid, dac_done,
        input  s_ready, dac_data, dac_start
    );

endinterface

// File: rtl/da3_sync_fifo.sv
// Single-clock FIFO with combinational head; a pushed word is readable the next cycle.
module da3_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/da3_sample_feeder.sv
// Paced sample source for the PmodDA3 driver: FIFO, sample-period timer, pending/flag logic, issue FSM.
// Define DA3_FEEDER_HOLD_LAST_EN to re-issue the last sample on an empty-FIFO tick.
module da3_sample_feeder
    import da3_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_W-1:0]    period,
    input  logic                   clear_flags,
    da3_sample_feeder_if.master    bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   underrun,
    output logic                   late
);

    da3_feed_state_t state_q, state_d;

    logic [DA3_DATA_W-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;

    logic [PERIOD_W-1:0]   count_q;
    logic [PERIOD_W-1:0]   period_q;
    logic [PERIOD_W-1:0]   period_eff;
    logic [PERIOD_W-1:0]   period_act;
    logic                  enable_q;
    logic                  enable_rise;
    logic                  tick;

    logic                  pending_q;
    logic                  go_issue;
    logic                  underrun_set;
    logic                  late_set;
    logic                  issue_pop_q;

    logic [DA3_DATA_W-1:0] dac_data_q;
    logic                  dac_start_q;
    logic                  busy_q;
    logic                  underrun_q;
    logic                  late_q;

    assign fifo_push = bus.s_valid && bus.s_ready;

    da3_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DA3_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.s_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // The first cycle of enable uses the live period so a freshly enabled timer honours it at once.
    assign period_eff  = (period == '0) ? PERIOD_W'(1) : period;
    assign enable_rise = enable && !enable_q;
    assign period_act  = enable_rise ? period_eff : period_q;
    assign tick        = enable && (count_q == period_act - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= 1'b0;
            count_q  <= '0;
            period_q <= PERIOD_W'(1);
        end else begin
            enable_q <= enable;
            if (!enable || tick) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + PERIOD_W'(1);
            end
            if (enable_rise || tick) begin
                period_q <= period_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        go_issue     = 1'b0;
        underrun_set = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    if (!fifo_empty) begin
                        go_issue = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        underrun_set = 1'b1;
`ifdef DA3_FEEDER_HOLD_LAST_EN
                        go_issue = 1'b1;
                        state_d  = ISSUE;
`endif
                    end
                end
            end
            ISSUE: begin
                fifo_pop = issue_pop_q;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.dac_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new tick outranks the clear from the issue decision so it is never lost.
    assign late_set = tick && pending_q;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pending_q <= 1'b0;
        end else if (tick) begin
            pending_q <= 1'b1;
        end else if (go_issue || underrun_set) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (clear_flags) begin
                underrun_q <= 1'b0;
            end
            if (late_set) begin
                late_q <= 1'b1;
            end else if (clear_flags) begin
                late_q <= 1'b0;
            end
        end
    end

    // Head is captured as ISSUE is entered and popped during ISSUE; a hold-last issue never pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data_q  <= '0;
            dac_start_q <= 1'b0;
            issue_pop_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            dac_start_q <= go_issue;
            issue_pop_q <= go_issue && !fifo_empty;
            busy_q      <= (state_d == WAIT_DONE);
            if (go_issue && !fifo_empty) begin
                dac_data_q <= fifo_head;
            end
        end
    end

    assign bus.s_ready   = !fifo_full;
    assign bus.dac_data  = dac_data_q;
    assign bus.dac_start = dac_start_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;
    assign late          = late_q;

endmodule

// File: tb/tb_da3_sample_feeder.sv
// Directed bench for da3_sample_feeder with a 20-cycle DAC driver model.
module tb_da3_sample_feeder;
    import da3_pkg::*;

    localparam int DEPTH    = 16;
    localparam int PERIOD_W = 16;
    localparam int DRV_LEN  = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                clear_flags;
    logic [PERIOD_W-1:0] period;
    logic [4:0]          level;
    logic                busy;
    logic                underrun;
    logic                late;

    da3_sample_feeder_if bus();

    int checks       = 0;
    int failures     = 0;
    int cycle        = 0;
    int overlapCount = 0;
    int stableErr    = 0;
    int startTimes[$];
    logic [15:0] dataLog[$];

    da3_sample_feeder #(
        .DEPTH    (DEPTH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .clear_flags (clear_flags),
        .bus         (bus),
        .level       (level),
        .busy        (busy),
        .underrun    (underrun),
        .late        (late)
    );

    initial forever #10 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Driver model: samples data one cycle after start, pulses done DRV_LEN cycles after start.
    initial begin : driverModel
        int drvCnt;
        bit drvActive;
        bit sampleNext;
        logic [15:0] sampled;
        drvCnt = 0;
        drvActive = 0;
        sampleNext = 0;
        sampled = '0;
        bus.dac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                drvActive = 0;
                drvCnt = 0;
                sampleNext = 0;
                bus.dac_done = 1'b0;
            end else begin
                bus.dac_done = 1'b0;
                if (sampleNext) begin
                    dataLog.push_back(bus.dac_data);
                    sampled = bus.dac_data;
                    sampleNext = 0;
                end
                if (drvActive) begin
                    drvCnt--;
                    if (drvCnt == 0) begin
                        if (bus.dac_data !== sampled) stableErr++;
                        bus.dac_done = 1'b1;
                        drvActive = 0;
                    end
                end
                if (bus.dac_start) begin
                    if (drvActive) overlapCount++;
                    drvActive = 1;
                    drvCnt = DRV_LEN;
                    sampleNext = 1;
                    startTimes.push_back(cycle);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] logAt(input int i);
        return (i < dataLog.size()) ? dataLog[i] : 16'hxxxx;
    endfunction

    function automatic int startAt(input int i);
        return (i < startTimes.size()) ? startTimes[i] : -1000;
    endfunction

    function automatic int orderErrors(input logic [15:0] base, input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (logAt(i) !== base + 16'(i)) errs++;
        end
        return errs;
    endfunction

    task automatic applyStimulus(input logic [15:0] d);
        int guard = 0;
        @(negedge clk);
        bus.s_data = d;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("push_ready", 32'(bus.s_ready), 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        clear_flags = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    task automatic waitStarts(input int n, input int budget);
        int k = 0;
        while (startTimes.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clearLogs();
        startTimes.delete();
        dataLog.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int accepted;
        int enCycle;
        int snap;
        int guard;
        reset = 1'b1;
        enable = 1'b0;
        clear_flags = 1'b0;
        period = 16'd32;
        bus.s_data = '0;
        bus.s_valid = 1'b0;

        resetDut();
        checkOutput("rst_start", 32'(bus.dac_start), 0);
        checkOutput("rst_data", 32'(bus.dac_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_underrun", 32'(underrun), 0);
        checkOutput("rst_late", 32'(late), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_ready", 32'(bus.s_ready), 1);

        $display("[TB] basic stream, period 32");
        applyStimulus(16'h1234);
        applyStimulus(16'hABCD);
        applyStimulus(16'h8000);
        checkOutput("basic_level3", 32'(level), 3);
        clearLogs();
        @(negedge clk);
        enable = 1'b1;
        enCycle = cycle;
        waitStarts(3, 200);
        repeat (25) @(negedge clk);
        checkOutput("basic_starts", 32'(startTimes.size()), 3);
        checkOutput("basic_latency", 32'(startAt(0) - enCycle), 33);
        checkOutput("basic_gap1", 32'(startAt(1) - startAt(0)), 32);
        checkOutput("basic_gap2", 32'(startAt(2) - startAt(1)), 32);
        checkOutput("basic_data0", 32'(logAt(0)), 32'h1234);
        checkOutput("basic_data1", 32'(logAt(1)), 32'hABCD);
        checkOutput("basic_data2", 32'(logAt(2)), 32'h8000);
        checkOutput("basic_stable", 32'(stableErr), 0);
        checkOutput("basic_level0", 32'(level), 0);
        checkOutput("basic_busy", 32'(busy), 0);
        checkOutput("basic_underrun", 32'(underrun), 0);
        checkOutput("basic_late", 32'(late), 0);
        checkOutput("basic_overlap", 32'(overlapCount), 0);
        enable = 1'b0;

        $display("[TB] underrun on empty FIFO");
        resetDut();
        clearLogs();
        period = 16'd32;
        @(negedge clk);
        enable = 1'b1;
        repeat (100) @(negedge clk);
`ifdef DA3_FEEDER_HOLD_LAST_EN
        checkOutput("urun_starts", 32'(startTimes.size()), 3);
        checkOutput("urun_data", 32'(logAt(0)), 0);
`else
        checkOutput("urun_starts", 32'(startTimes.size()), 0);
`endif
        checkOutput("urun_flag", 32'(underrun), 1);
        enable = 1'b0;
        repeat (25) @(negedge clk);
        pulseClear();
        checkOutput("urun_clear", 32'(underrun), 0);

        $display("[TB] backpressure with 20 pushes");
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.s_data = 16'h0100 + 16'(accepted);
            bus.s_valid = 1'b1;
            if (bus.s_ready) accepted++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        checkOutput("bp_accepted", 32'(accepted), 16);
        checkOutput("bp_ready_low", 32'(bus.s_ready), 0);
        checkOutput("bp_level16", 32'(level), 16);
        clearLogs();
        period = 16'd32;
        @(negedge clk);
        enable = 1'b1;
        waitStarts(16, 700);
        repeat (25) @(negedge clk);
        checkOutput("bp_starts", 32'(startTimes.size()), 16);
        checkOutput("bp_order", 32'(orderErrors(16'h0100, 16)), 0);
        checkOutput("bp_level0", 32'(level), 0);
        checkOutput("bp_late", 32'(late), 0);
        enable = 1'b0;
        repeat (25) @(negedge clk);

        $display("[TB] late with period 5");
        resetDut();
        clearLogs();
        period = 16'd5;
        for (int i = 0; i < 4; i++) applyStimulus(16'h0A01 + 16'(i));
        @(negedge clk);
        enable = 1'b1;
        waitStarts(4, 400);
        snap = startTimes.size();
        repeat (25) @(negedge clk);
        checkOutput("late_starts", 32'(snap), 4);
        checkOutput("late_flag", 32'(late), 1);
        checkOutput("late_order", 32'(orderErrors(16'h0A01, 4)), 0);
        checkOutput("late_level", 32'(level), 0);
        enable = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("late_overlap", 32'(overlapCount), 0);
        pulseClear();
        checkOutput("late_clear", 32'(late), 0);

        $display("[TB] reset during transfer");
        resetDut();
        clearLogs();
        period = 16'd32;
        for (int i = 0; i < 4; i++) applyStimulus(16'h0C01 + 16'(i));
        @(negedge clk);
        enable = 1'b1;
        guard = 0;
        while (!busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("mid_busy", 32'(busy), 1);
        checkOutput("mid_level3", 32'(level), 3);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        snap = startTimes.size();
        checkOutput("mid_start", 32'(bus.dac_start), 0);
        checkOutput("mid_data", 32'(bus.dac_data), 0);
        checkOutput("mid_busy0", 32'(busy), 0);
        checkOutput("mid_level0", 32'(level), 0);
        checkOutput("mid_ready", 32'(bus.s_ready), 1);
        checkOutput("mid_flags", 32'({underrun, late}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("mid_no_start", 32'(startTimes.size()), 32'(snap));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
